// File: rtl/maze_episode_sequencer.sv
// Q-learning episode sequencer for a 6x6 maze: requests an action, computes the
// wall-clamped next cell, captures the reward and hands the transition to the
// Q-update unit over valid/ready, while counting steps and episodes.
module maze_episode_sequencer #(
    parameter int unsigned START_STATE  = 0,
    parameter int unsigned MAX_STEPS    = 255,
    parameter int unsigned NUM_EPISODES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               act_req,
    input  logic               act_valid,
    input  logic [1:0]         act,
    output logic [5:0]         cur_state,
    output logic [5:0]         next_state,
    input  logic signed [15:0] reward,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [5:0]         upd_state,
    output logic [1:0]         upd_action,
    output logic [5:0]         upd_next,
    output logic signed [15:0] upd_reward,
    output logic               upd_terminal,
    output logic [7:0]         step_cnt,
    output logic [15:0]        episode_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {S_IDLE, S_ACT, S_MOVE, S_UPD, S_DONE} state_t;

    localparam logic [5:0]  START_CELL = 6'(START_STATE);
    localparam logic [8:0]  STEP_LIMIT = 9'(MAX_STEPS);
    localparam logic [16:0] EP_LIMIT   = 17'(NUM_EPISODES);

    state_t             state_q, state_d;
    logic [5:0]         cur_state_q, cur_state_d;
    logic [5:0]         next_state_q, next_state_d;
    logic [5:0]         upd_state_q, upd_state_d;
    logic [1:0]         upd_action_q, upd_action_d;
    logic [5:0]         upd_next_q, upd_next_d;
    logic signed [15:0] upd_reward_q, upd_reward_d;
    logic               upd_terminal_q, upd_terminal_d;
    logic [7:0]         step_cnt_q, step_cnt_d;
    logic [15:0]        episode_cnt_q, episode_cnt_d;

    logic [8:0]  step_inc;
    logic [16:0] ep_inc;
    logic        ep_end;
    logic        last_ep;

    // Wall-clamped move on the 6x6 grid
    function automatic logic [5:0] move_cell(input logic [5:0] s, input logic [1:0] a);
        logic [5:0] row;
        logic [5:0] col;
        logic [5:0] r;
        row = s / 6'd6;
        col = s % 6'd6;
        r   = s;
        case (a)
            2'd0:    if (row != 6'd0) r = s - 6'd6;
            2'd1:    if (row < 6'd5)  r = s + 6'd6;
            2'd2:    if (col != 6'd0) r = s - 6'd1;
            default: if (col < 6'd5)  r = s + 6'd1;
        endcase
        return r;
    endfunction

    assign step_inc = {1'b0, step_cnt_q} + 9'd1;
    assign ep_inc   = {1'b0, episode_cnt_q} + 17'd1;
    assign ep_end   = upd_terminal_q || (step_inc == STEP_LIMIT);
    assign last_ep  = (ep_inc == EP_LIMIT);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cur_state_q    <= START_CELL;
            next_state_q   <= '0;
            upd_state_q    <= '0;
            upd_action_q   <= '0;
            upd_next_q     <= '0;
            upd_reward_q   <= '0;
            upd_terminal_q <= 1'b0;
            step_cnt_q     <= '0;
            episode_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            cur_state_q    <= cur_state_d;
            next_state_q   <= next_state_d;
            upd_state_q    <= upd_state_d;
            upd_action_q   <= upd_action_d;
            upd_next_q     <= upd_next_d;
            upd_reward_q   <= upd_reward_d;
            upd_terminal_q <= upd_terminal_d;
            step_cnt_q     <= step_cnt_d;
            episode_cnt_q  <= episode_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_ACT;
            S_ACT:          if (act_valid) state_d = S_MOVE;
            S_MOVE:         state_d = S_UPD;
            S_UPD:          if (upd_ready) state_d = (ep_end && last_ep) ? S_DONE : S_ACT;
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath updates: action capture, transition latch, counters on handshake
    always_comb begin
        cur_state_d    = cur_state_q;
        next_state_d   = next_state_q;
        upd_state_d    = upd_state_q;
        upd_action_d   = upd_action_q;
        upd_next_d     = upd_next_q;
        upd_reward_d   = upd_reward_q;
        upd_terminal_d = upd_terminal_q;
        step_cnt_d     = step_cnt_q;
        episode_cnt_d  = episode_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cur_state_d   = START_CELL;
                    step_cnt_d    = '0;
                    episode_cnt_d = '0;
                end
            end
            S_ACT: begin
                if (act_valid) begin
                    upd_action_d = act;
                    next_state_d = move_cell(cur_state_q, act);
                end
            end
            S_MOVE: begin
                upd_reward_d   = reward;
                upd_state_d    = cur_state_q;
                upd_next_d     = next_state_q;
                upd_terminal_d = (reward != '0);
            end
            S_UPD: begin
                if (upd_ready) begin
                    step_cnt_d = step_inc[7:0];
                    if (ep_end) begin
                        episode_cnt_d = ep_inc[15:0];
                        if (!last_ep) begin
                            cur_state_d = START_CELL;
                            step_cnt_d  = '0;
                        end
                    end else begin
                        cur_state_d = upd_next_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        act_req   = (state_q == S_ACT);
        upd_valid = (state_q == S_UPD);
        busy      = (state_q == S_ACT) || (state_q == S_MOVE) || (state_q == S_UPD);
        done      = (state_q == S_DONE);
    end

    assign cur_state    = cur_state_q;
    assign next_state   = next_state_q;
    assign upd_state    = upd_state_q;
    assign upd_action   = upd_action_q;
    assign upd_next     = upd_next_q;
    assign upd_reward   = upd_reward_q;
    assign upd_terminal = upd_terminal_q;
    assign step_cnt     = step_cnt_q;
    assign episode_cnt  = episode_cnt_q;

endmodule

// File: tb/tb_maze_episode_sequencer.sv
// Scoreboard bench for maze_episode_sequencer: the driver pushes expected
// transitions from a grid-level model, the monitor pops them on each handshake.
module tb_maze_episode_sequencer;

    localparam int unsigned START = 0;
    localparam int unsigned MAXS  = 6;
    localparam int unsigned NEP   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               act_req;
    logic               act_valid = 1'b0;
    logic [1:0]         act = 2'd0;
    logic [5:0]         cur_state;
    logic [5:0]         next_state;
    logic signed [15:0] reward;
    logic               upd_valid;
    logic               upd_ready = 1'b0;
    logic [5:0]         upd_state;
    logic [1:0]         upd_action;
    logic [5:0]         upd_next;
    logic signed [15:0] upd_reward;
    logic               upd_terminal;
    logic [7:0]         step_cnt;
    logic [15:0]        episode_cnt;
    logic               busy;
    logic               done;

    maze_episode_sequencer #(
        .START_STATE (START),
        .MAX_STEPS   (MAXS),
        .NUM_EPISODES(NEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .act_req     (act_req),
        .act_valid   (act_valid),
        .act         (act),
        .cur_state   (cur_state),
        .next_state  (next_state),
        .reward      (reward),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_state   (upd_state),
        .upd_action  (upd_action),
        .upd_next    (upd_next),
        .upd_reward  (upd_reward),
        .upd_terminal(upd_terminal),
        .step_cnt    (step_cnt),
        .episode_cnt (episode_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reward generator: goal at 25, pit at 3
    function automatic logic [15:0] rew_of(input logic [5:0] s);
        if (s == 6'd25) return 16'd100;
        if (s == 6'd3)  return 16'hFF9C;
        return 16'd0;
    endfunction

    always_comb reward = rew_of(next_state);

    // Grid model: row/col clamped to 0..5
    function automatic logic [5:0] model_move(input logic [5:0] s, input logic [1:0] a);
        int r;
        int c;
        r = int'(s) / 6;
        c = int'(s) % 6;
        case (a)
            2'd0: if (r > 0) r = r - 1;
            2'd1: if (r < 5) r = r + 1;
            2'd2: if (c > 0) c = c - 1;
            default: if (c < 5) c = c + 1;
        endcase
        return 6'(r * 6 + c);
    endfunction

    typedef struct {
        logic [5:0]  s;
        logic [1:0]  a;
        logic [5:0]  n;
        logic [15:0] r;
        logic        t;
        logic [5:0]  pc;
        logic [7:0]  ps;
        logic [15:0] pe;
        logic        pd;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    int m_cur  = START;
    int m_step = 0;
    int m_ep   = 0;
    bit m_done = 1'b0;
    bit m_run  = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctl"},
              64'({act_req, upd_valid, busy, done, cur_state, next_state, step_cnt, episode_cnt}),
              64'({4'b0000, 6'(START), 6'd0, 8'd0, 16'd0}));
        check({name, "_upd"},
              64'({upd_state, upd_action, upd_next, upd_reward, upd_terminal}),
              64'd0);
    endtask

    task automatic model_reset();
        m_cur  = START;
        m_step = 0;
        m_ep   = 0;
        m_done = 1'b0;
        m_run  = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        check_reset("reset_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        check("pre_start_act_req", 64'(act_req), 64'd0);
        start = 1'b1;
        m_cur  = START;
        m_step = 0;
        m_ep   = 0;
        m_done = 1'b0;
        m_run  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_resp",
              64'({act_req, busy, done, cur_state, step_cnt, episode_cnt}),
              64'({1'b1, 1'b1, 1'b0, 6'(START), 8'd0, 16'd0}));
    endtask

    task automatic do_step(input logic [1:0] a, input int act_dly, input int rdy_dly,
                           input bit noise, input bit start_in_move, input bit rst_in_upd);
        exp_t e;
        int k;
        int ns;
        k = 0;
        while (!act_req && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!act_req) begin
            total++;
            bad++;
            $display("FAIL act_req_timeout: act_req=0 required 1");
            return;
        end
        repeat (act_dly) begin
            @(posedge clk); #1;
        end
        act_valid = 1'b1;
        act = a;
        e.s = 6'(m_cur);
        e.a = a;
        e.n = model_move(6'(m_cur), a);
        e.r = rew_of(e.n);
        e.t = (e.r != 16'd0);
        ns = m_step + 1;
        if (e.t || ns == int'(MAXS)) begin
            m_ep++;
            if (m_ep == int'(NEP)) begin
                m_done = 1'b1;
                m_run  = 1'b0;
                m_step = ns;
            end else begin
                m_cur  = START;
                m_step = 0;
            end
        end else begin
            m_cur  = e.n;
            m_step = ns;
        end
        e.pc = 6'(m_cur);
        e.ps = 8'(m_step);
        e.pe = 16'(m_ep);
        e.pd = m_done;
        q.push_back(e);

        @(posedge clk); #1;
        act = 2'($urandom);
        act_valid = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        start = start_in_move | (noise & 1'($urandom_range(1, 0)));
        check("move_phase", 64'({act_req, busy, upd_valid, next_state}), 64'({1'b0, 1'b1, 1'b0, e.n}));

        @(posedge clk); #1;
        act_valid = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        check("upd_rise", 64'({upd_valid, act_req}), 64'({1'b1, 1'b0}));

        if (rst_in_upd) begin
            upd_ready = 1'b0;
            check("upd_fields_pre_reset",
                  64'({upd_state, upd_action, upd_next, upd_reward, upd_terminal}),
                  64'({e.s, e.a, e.n, e.r, e.t}));
            rst_n = 1'b0;
            #1;
            check_reset("async_reset");
            void'(q.pop_back());
            model_reset();
            @(posedge clk); #1;
            rst_n = 1'b1;
            start = 1'b0;
            act_valid = 1'b0;
            check_reset("after_reset");
            return;
        end

        if (rdy_dly > 0) begin
            upd_ready = 1'b0;
            repeat (rdy_dly) begin
                @(posedge clk); #1;
                act_valid = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                check("bp_hold",
                      64'({upd_valid, act_req, cur_state, upd_state, upd_action, upd_next, upd_reward, upd_terminal}),
                      64'({1'b1, 1'b0, e.s, e.s, e.a, e.n, e.r, e.t}));
            end
        end
        upd_ready = 1'b1;
        @(posedge clk); #1;
        upd_ready = 1'b0;
        act_valid = 1'b0;
        start = 1'b0;
    endtask

    // Monitor: pops one expected transition per handshake, then checks the
    // counters and status one cycle later
    initial begin
        exp_t e;
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("post_handshake",
                      64'({cur_state, step_cnt, episode_cnt, done, busy, act_req, upd_valid}),
                      64'({e.pc, e.ps, e.pe, e.pd, !e.pd, !e.pd, 1'b0}));
                pend = 1'b0;
            end
            if (rst_n && upd_valid && upd_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_transition: upd handshake with no expected entry");
                end else begin
                    e = q.pop_front();
                    check("transition",
                          64'({upd_state, upd_action, upd_next, upd_reward, upd_terminal}),
                          64'({e.s, e.a, e.n, e.r, e.t}));
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #12;
        check_reset("reset_init");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset("idle_after_reset");

        // wall move up from cell 0
        do_start();
        do_step(2'd0, 0, 0, 1'b0, 1'b0, 1'b0);

        // pit at 3, then a backpressured step down
        apply_reset();
        do_start();
        repeat (3) do_step(2'd3, 0, 0, 1'b0, 1'b0, 1'b0);
        do_step(2'd1, 0, 5, 1'b0, 1'b0, 1'b0);

        // truncation by step limit against the left wall
        apply_reset();
        do_start();
        repeat (MAXS) do_step(2'd2, 0, 0, 1'b0, 1'b0, 1'b0);

        // two episodes reaching the goal complete the run
        apply_reset();
        do_start();
        repeat (2) begin
            repeat (4) do_step(2'd1, 0, 0, 1'b0, 1'b0, 1'b0);
            do_step(2'd3, 0, 0, 1'b0, 1'b0, 1'b0);
        end
        check("run_done", 64'({done, busy, act_req, episode_cnt}), 64'({1'b1, 1'b0, 1'b0, 16'd2}));
        repeat (3) @(posedge clk);
        #1;
        check("done_holds", 64'({done, episode_cnt}), 64'({1'b1, 16'd2}));
        do_start();

        // start during MOVE ignored, reset during UPD
        do_step(2'd3, 0, 0, 1'b0, 1'b1, 1'b1);

        // randomized traffic with noise on start/act_valid while busy
        for (int i = 0; i < 200; i++) begin
            if (!m_run) do_start();
            do_step(2'($urandom), $urandom_range(2, 0), $urandom_range(3, 0), 1'b1, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
